// File: rtl/axil_reg_pkg.sv
// Shared response codes, address-region decode and write-response states
// for the AXI4-Lite register slave.
package axil_reg_pkg;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    REG_CTRL,
    REG_STAT,
    REG_UNMAPPED
  } region_t;

  typedef enum logic {
    B_IDLE,
    B_RESP
  } bstate_t;

  // Control registers occupy the bottom of the word map, status registers follow.
  function automatic region_t decode_region(input int idx, input int nctrl, input int nstat);
    if (idx < nctrl) begin
      return REG_CTRL;
    end else if (idx < nctrl + nstat) begin
      return REG_STAT;
    end
    return REG_UNMAPPED;
  endfunction

endpackage

// File: rtl/axil_reg_if.sv
// AXI4-Lite bus bundle (32-bit address and data) with master and slave views.
interface axi_lite;

  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/axil_reg_wr_capture.sv
// Write-side front end: captures AW and W beats independently, issues a one-cycle
// commit once both are held, and owns the B response until the master accepts it.
module axil_reg_wr_capture
  import axil_reg_pkg::*;
#(
  parameter  int NUM_CTRL_REGS = 8,
  parameter  int NUM_STAT_REGS = 8,
  parameter  int ADDR_BITS     = 12,
  localparam int IDX_W         = ADDR_BITS - 2
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             i_en,
  input  logic             i_awvalid,
  input  logic [IDX_W-1:0] i_awidx,
  output logic             o_awready,
  input  logic             i_wvalid,
  input  logic [31:0]      i_wdata,
  input  logic [3:0]       i_wstrb,
  output logic             o_wready,
  output logic             o_bvalid,
  output logic [1:0]       o_bresp,
  input  logic             i_bready,
  output logic             o_commit,
  output region_t          o_cmt_region,
  output logic [IDX_W-1:0] o_cmt_idx,
  output logic [31:0]      o_cmt_data,
  output logic [3:0]       o_cmt_strb
);

  bstate_t          r_bstate;
  bstate_t          w_bstate_next;
  logic             r_aw_held;
  logic             r_w_held;
  logic [IDX_W-1:0] r_awidx;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic [1:0]       r_bresp;
  region_t          w_region;
  logic             w_aw_hs;
  logic             w_w_hs;
  logic             w_b_hs;

  assign o_awready = i_en && !r_aw_held && !o_bvalid;
  assign o_wready  = i_en && !r_w_held && !o_bvalid;
  assign w_aw_hs   = i_awvalid && o_awready;
  assign w_w_hs    = i_wvalid && o_wready;
  assign w_b_hs    = o_bvalid && i_bready;
  assign w_region  = decode_region(int'(r_awidx), NUM_CTRL_REGS, NUM_STAT_REGS);

  assign o_bresp      = r_bresp;
  assign o_cmt_region = w_region;
  assign o_cmt_idx    = r_awidx;
  assign o_cmt_data   = r_wdata;
  assign o_cmt_strb   = r_wstrb;

  // Held beats survive until the B handshake so the response always matches them.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_awidx   <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
    end else if (w_b_hs) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
    end else begin
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awidx   <= i_awidx;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= i_wdata;
        r_wstrb  <= i_wstrb;
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_bstate <= B_IDLE;
      r_bresp  <= AXIL_RESP_OKAY;
    end else begin
      r_bstate <= w_bstate_next;
      if (o_commit) begin
        unique case (w_region)
          REG_CTRL: r_bresp <= AXIL_RESP_OKAY;
          REG_STAT: r_bresp <= AXIL_RESP_SLVERR;
          default:  r_bresp <= AXIL_RESP_DECERR;
        endcase
      end
    end
  end

  always_comb begin
    w_bstate_next = r_bstate;
    o_bvalid      = 1'b0;
    o_commit      = 1'b0;
    case (r_bstate)
      B_IDLE: begin
        if (r_aw_held && r_w_held) begin
          o_commit      = 1'b1;
          w_bstate_next = B_RESP;
        end
      end
      B_RESP: begin
        o_bvalid = 1'b1;
        if (i_bready) begin
          w_bstate_next = B_IDLE;
        end
      end
      default: w_bstate_next = B_IDLE;
    endcase
  end

endmodule

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: RW control registers followed by RO status registers
// in a 4 KB word-addressed window, with write/read strobes for the attached block.
module axil_reg_slave
  import axil_reg_pkg::*;
#(
  parameter  int          NUM_CTRL_REGS = 8,
  parameter  int          NUM_STAT_REGS = 8,
  parameter  logic [31:0] CTRL_RST_VAL  = 32'h0000_0000,
  parameter  int          ADDR_BITS     = 12,
  localparam int          STAT_W        = (NUM_STAT_REGS > 0) ? NUM_STAT_REGS : 1,
  localparam int          IDX_W         = ADDR_BITS - 2
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  axi_lite.slave                     s_axil,
  output logic [NUM_CTRL_REGS*32-1:0] ctrl_regs,
  output logic [NUM_CTRL_REGS-1:0]    ctrl_wr_pulse,
  input  logic [STAT_W*32-1:0]        stat_regs,
  output logic [STAT_W-1:0]           stat_rd_pulse
);

  localparam int CIDX_W = (NUM_CTRL_REGS > 1) ? $clog2(NUM_CTRL_REGS) : 1;
  localparam int SIDX_W = (STAT_W > 1) ? $clog2(STAT_W) : 1;

  logic                     r_en;
  logic [31:0]              r_ctrl [NUM_CTRL_REGS];
  logic [NUM_CTRL_REGS-1:0] r_wr_pulse;
  logic [STAT_W-1:0]        r_stat_pulse;
  logic                     r_rvalid;
  logic [31:0]              r_rdata;
  logic [1:0]               r_rresp;
  logic [31:0]              w_stat [STAT_W];

  logic                     w_commit;
  region_t                  w_cmt_region;
  logic [IDX_W-1:0]         w_cmt_idx;
  logic [31:0]              w_cmt_data;
  logic [3:0]               w_cmt_strb;
  logic [CIDX_W-1:0]        w_cmt_cidx;

  logic [IDX_W-1:0]         w_aridx;
  logic [IDX_W-1:0]         w_ar_sdiff;
  logic [CIDX_W-1:0]        w_ar_cidx;
  logic [SIDX_W-1:0]        w_ar_sidx;
  region_t                  w_ar_region;
  logic                     w_ar_hs;
  logic [31:0]              w_rd_data;
  logic                     w_unused;

  // Readies stay low until the first clock after reset release.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_en <= 1'b0;
    end else begin
      r_en <= 1'b1;
    end
  end

  axil_reg_wr_capture #(
    .NUM_CTRL_REGS (NUM_CTRL_REGS),
    .NUM_STAT_REGS (NUM_STAT_REGS),
    .ADDR_BITS     (ADDR_BITS)
  ) u_wr_capture (
    .aclk         (aclk),
    .aresetn      (aresetn),
    .i_en         (r_en),
    .i_awvalid    (s_axil.awvalid),
    .i_awidx      (s_axil.awaddr[ADDR_BITS-1:2]),
    .o_awready    (s_axil.awready),
    .i_wvalid     (s_axil.wvalid),
    .i_wdata      (s_axil.wdata),
    .i_wstrb      (s_axil.wstrb),
    .o_wready     (s_axil.wready),
    .o_bvalid     (s_axil.bvalid),
    .o_bresp      (s_axil.bresp),
    .i_bready     (s_axil.bready),
    .o_commit     (w_commit),
    .o_cmt_region (w_cmt_region),
    .o_cmt_idx    (w_cmt_idx),
    .o_cmt_data   (w_cmt_data),
    .o_cmt_strb   (w_cmt_strb)
  );

  assign w_cmt_cidx = w_cmt_idx[CIDX_W-1:0];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_CTRL_REGS; i++) begin
        r_ctrl[i] <= CTRL_RST_VAL;
      end
      r_wr_pulse <= '0;
    end else begin
      r_wr_pulse <= '0;
      if (w_commit && (w_cmt_region == REG_CTRL)) begin
        r_wr_pulse[w_cmt_cidx] <= 1'b1;
        for (int b = 0; b < 4; b++) begin
          if (w_cmt_strb[b]) begin
            r_ctrl[w_cmt_cidx][b*8 +: 8] <= w_cmt_data[b*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CTRL_REGS; g++) begin : g_ctrl_out
    assign ctrl_regs[g*32 +: 32] = r_ctrl[g];
  end

  for (genvar g = 0; g < STAT_W; g++) begin : g_stat_in
    assign w_stat[g] = stat_regs[g*32 +: 32];
  end

  assign ctrl_wr_pulse = r_wr_pulse;
  assign stat_rd_pulse = r_stat_pulse;

  assign w_aridx     = s_axil.araddr[ADDR_BITS-1:2];
  assign w_ar_sdiff  = w_aridx - IDX_W'(NUM_CTRL_REGS);
  assign w_ar_cidx   = w_aridx[CIDX_W-1:0];
  assign w_ar_sidx   = w_ar_sdiff[SIDX_W-1:0];
  assign w_ar_region = decode_region(int'(w_aridx), NUM_CTRL_REGS, NUM_STAT_REGS);
  assign w_ar_hs     = s_axil.arvalid && s_axil.arready;

  always_comb begin
    w_rd_data = 32'h0;
    case (w_ar_region)
      REG_CTRL: w_rd_data = r_ctrl[w_ar_cidx];
      REG_STAT: w_rd_data = w_stat[w_ar_sidx];
      default:  w_rd_data = 32'h0;
    endcase
  end

  // Register array is sampled before any same-cycle commit lands, so a colliding read sees the old value.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rvalid     <= 1'b0;
      r_rdata      <= 32'h0;
      r_rresp      <= AXIL_RESP_OKAY;
      r_stat_pulse <= '0;
    end else begin
      r_stat_pulse <= '0;
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_data;
        r_rresp  <= (w_ar_region == REG_UNMAPPED) ? AXIL_RESP_DECERR : AXIL_RESP_OKAY;
        if (w_ar_region == REG_STAT) begin
          r_stat_pulse[w_ar_sidx] <= 1'b1;
        end
      end else if (r_rvalid && s_axil.rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign s_axil.arready = r_en && !r_rvalid;
  assign s_axil.rvalid  = r_rvalid;
  assign s_axil.rdata   = r_rdata;
  assign s_axil.rresp   = r_rresp;

  assign w_unused = ^{s_axil.awaddr[31:ADDR_BITS], s_axil.awaddr[1:0],
                      s_axil.araddr[31:ADDR_BITS], s_axil.araddr[1:0],
                      w_cmt_idx[IDX_W-1:CIDX_W], w_ar_sdiff[IDX_W-1:SIDX_W]};

endmodule

// File: tb/tb_axil_reg_slave.sv
// Directed self-checking bench for axil_reg_slave: reset, byte strobes, W-before-AW,
// status/unmapped responses, B backpressure, read/write collision and mid-write reset.
module tb_axil_reg_slave;

  localparam int NCTRL = 8;
  localparam int NSTAT = 8;

  logic aclk = 1'b0;
  logic aresetn;

  // Free-running 10 ns clock; the bench drives and samples on the falling edge.
  always #5 aclk = ~aclk;

  axi_lite busIf ();

  logic [NCTRL*32-1:0] ctrlRegs;
  logic [NCTRL-1:0]    ctrlWrPulse;
  logic [NSTAT*32-1:0] statRegs;
  logic [NSTAT-1:0]    statRdPulse;

  int numCompared   = 0;
  int numMismatched = 0;

  axil_reg_slave #(
    .NUM_CTRL_REGS (NCTRL),
    .NUM_STAT_REGS (NSTAT),
    .CTRL_RST_VAL  (32'h0000_0000),
    .ADDR_BITS     (12)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axil        (busIf),
    .ctrl_regs     (ctrlRegs),
    .ctrl_wr_pulse (ctrlWrPulse),
    .stat_regs     (statRegs),
    .stat_rd_pulse (statRdPulse)
  );

  // Single point of comparison: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    numCompared++;
    if (observed !== expected) begin
      numMismatched++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] ctrlWord(input int i);
    return ctrlRegs[i*32 +: 32];
  endfunction

  // Presents AW and W together and waits for bvalid, leaving bready low.
  task automatic writeIssue(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output logic [NCTRL-1:0] pulse);
    int  cnt;
    logic awGo, wGo;
    @(negedge aclk);
    busIf.awaddr  = addr;
    busIf.awvalid = 1'b1;
    busIf.wdata   = data;
    busIf.wstrb   = strb;
    busIf.wvalid  = 1'b1;
    cnt = 0;
    while ((busIf.awvalid || busIf.wvalid) && cnt < 20) begin
      awGo = busIf.awvalid && busIf.awready;
      wGo  = busIf.wvalid && busIf.wready;
      @(negedge aclk);
      if (awGo) busIf.awvalid = 1'b0;
      if (wGo)  busIf.wvalid  = 1'b0;
      cnt++;
    end
    checkOutput("aw_w_accept_cycles", 32'(cnt), 32'd1);
    busIf.awvalid = 1'b0;
    busIf.wvalid  = 1'b0;
    cnt = 0;
    while (!busIf.bvalid && cnt < 20) begin
      @(negedge aclk);
      cnt++;
    end
    checkOutput("b_latency", 32'(cnt), 32'd1);
    resp  = busIf.bresp;
    pulse = ctrlWrPulse;
  endtask

  task automatic writeFinish();
    busIf.bready = 1'b1;
    @(negedge aclk);
    busIf.bready = 1'b0;
    checkOutput("wr_pulse_one_cycle", 32'(ctrlWrPulse), 32'd0);
    checkOutput("awready_after_b", 32'(busIf.awready), 32'd1);
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               output logic [1:0] resp, output logic [NCTRL-1:0] pulse);
    writeIssue(addr, data, strb, resp, pulse);
    writeFinish();
  endtask

  task automatic readAxil(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                          output logic [NSTAT-1:0] pulse);
    int cnt;
    @(negedge aclk);
    busIf.araddr  = addr;
    busIf.arvalid = 1'b1;
    cnt = 0;
    while (!busIf.arready && cnt < 20) begin
      @(negedge aclk);
      cnt++;
    end
    checkOutput("ar_accept_wait", 32'(cnt), 32'd0);
    @(negedge aclk);
    busIf.arvalid = 1'b0;
    checkOutput("rd_latency_rvalid", 32'(busIf.rvalid), 32'd1);
    data  = busIf.rdata;
    resp  = busIf.rresp;
    pulse = statRdPulse;
    busIf.rready = 1'b1;
    @(negedge aclk);
    busIf.rready = 1'b0;
    checkOutput("rd_pulse_one_cycle", 32'(statRdPulse), 32'd0);
    checkOutput("arready_after_r", 32'(busIf.arready), 32'd1);
  endtask

  initial begin
    logic [1:0]       resp;
    logic [NCTRL-1:0] wp;
    logic [NSTAT-1:0] sp;
    logic [31:0]      rd;
    int               stallBad;
    int               waitBad;

    aresetn       = 1'b0;
    busIf.awaddr  = '0;
    busIf.awvalid = 1'b0;
    busIf.wdata   = '0;
    busIf.wstrb   = '0;
    busIf.wvalid  = 1'b0;
    busIf.bready  = 1'b0;
    busIf.araddr  = '0;
    busIf.arvalid = 1'b0;
    busIf.rready  = 1'b0;
    statRegs = {32'h7777_0007, 32'h6666_0006, 32'h5555_0005, 32'h4444_0004,
                32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'hCAFE_0001};

    // Reset: readies and responses low, registers at reset value.
    repeat (5) @(negedge aclk);
    checkOutput("rst_awready", 32'(busIf.awready), 32'd0);
    checkOutput("rst_wready", 32'(busIf.wready), 32'd0);
    checkOutput("rst_arready", 32'(busIf.arready), 32'd0);
    checkOutput("rst_bvalid", 32'(busIf.bvalid), 32'd0);
    checkOutput("rst_rvalid", 32'(busIf.rvalid), 32'd0);
    checkOutput("rst_rdata", busIf.rdata, 32'h0);
    for (int i = 0; i < NCTRL; i++) checkOutput($sformatf("rst_ctrl%0d", i), ctrlWord(i), 32'h0);
    aresetn = 1'b1;
    @(negedge aclk);
    checkOutput("rel_awready", 32'(busIf.awready), 32'd1);
    checkOutput("rel_wready", 32'(busIf.wready), 32'd1);
    checkOutput("rel_arready", 32'(busIf.arready), 32'd1);

    // Full-word write then read back.
    applyStimulus(32'h004, 32'hDEAD_BEEF, 4'hF, resp, wp);
    checkOutput("t2_bresp", 32'(resp), 32'h0);
    checkOutput("t2_wr_pulse", 32'(wp), 32'h02);
    readAxil(32'h004, rd, resp, sp);
    checkOutput("t2_rdata", rd, 32'hDEAD_BEEF);
    checkOutput("t2_rresp", 32'(resp), 32'h0);
    readAxil(32'h1004, rd, resp, sp);
    checkOutput("t2_upper_addr_ignored", rd, 32'hDEAD_BEEF);

    // W before AW, partial strobes.
    @(negedge aclk);
    busIf.wdata  = 32'h1122_3344;
    busIf.wstrb  = 4'b0101;
    busIf.wvalid = 1'b1;
    @(negedge aclk);
    busIf.wvalid = 1'b0;
    waitBad = 0;
    repeat (3) begin
      @(negedge aclk);
      if (busIf.wready || busIf.bvalid || !busIf.awready) waitBad++;
    end
    checkOutput("t3_w_held_idle", 32'(waitBad), 32'd0);
    busIf.awaddr  = 32'h000;
    busIf.awvalid = 1'b1;
    @(negedge aclk);
    busIf.awvalid = 1'b0;
    checkOutput("t3_commit_bvalid_low", 32'(busIf.bvalid), 32'd0);
    @(negedge aclk);
    checkOutput("t3_bvalid_after_commit", 32'(busIf.bvalid), 32'd1);
    checkOutput("t3_bresp", 32'(busIf.bresp), 32'h0);
    checkOutput("t3_wr_pulse", 32'(ctrlWrPulse), 32'h01);
    writeFinish();
    checkOutput("t3_reg0", ctrlWord(0), 32'h0022_0044);

    // Zero strobe: no byte changes, pulse and OKAY still occur.
    applyStimulus(32'h004, 32'h0000_0000, 4'h0, resp, wp);
    checkOutput("strb0_bresp", 32'(resp), 32'h0);
    checkOutput("strb0_pulse", 32'(wp), 32'h02);
    checkOutput("strb0_reg1", ctrlWord(1), 32'hDEAD_BEEF);

    // Status, SLVERR and DECERR regions.
    readAxil(32'h020, rd, resp, sp);
    checkOutput("t4_stat0_rdata", rd, 32'hCAFE_0001);
    checkOutput("t4_stat0_rresp", 32'(resp), 32'h0);
    checkOutput("t4_stat0_pulse", 32'(sp), 32'h01);
    readAxil(32'h03E, rd, resp, sp);
    checkOutput("t4_stat7_rdata", rd, 32'h7777_0007);
    checkOutput("t4_stat7_pulse", 32'(sp), 32'h80);
    readAxil(32'h01C, rd, resp, sp);
    checkOutput("t4_ctrl7_rdata", rd, 32'h0);
    checkOutput("t4_ctrl7_no_stat_pulse", 32'(sp), 32'h0);
    applyStimulus(32'h020, 32'h1234_5678, 4'hF, resp, wp);
    checkOutput("t4_stat_wr_bresp", 32'(resp), 32'h2);
    checkOutput("t4_stat_wr_no_pulse", 32'(wp), 32'h0);
    checkOutput("t4_reg0_unchanged", ctrlWord(0), 32'h0022_0044);
    checkOutput("t4_reg1_unchanged", ctrlWord(1), 32'hDEAD_BEEF);
    applyStimulus(32'h040, 32'h1234_5678, 4'hF, resp, wp);
    checkOutput("t4_unmapped_wr_bresp", 32'(resp), 32'h3);
    readAxil(32'h400, rd, resp, sp);
    checkOutput("t4_unmapped_rresp", 32'(resp), 32'h3);
    checkOutput("t4_unmapped_rdata", rd, 32'h0);
    checkOutput("t4_unmapped_no_pulse", 32'(sp), 32'h0);

    // B backpressure while the read path keeps working.
    writeIssue(32'h008, 32'hA5A5_5A5A, 4'hF, resp, wp);
    checkOutput("t5_bresp", 32'(resp), 32'h0);
    checkOutput("t5_wr_pulse", 32'(wp), 32'h04);
    stallBad = 0;
    fork
      begin
        repeat (10) begin
          @(negedge aclk);
          if (busIf.awready || busIf.wready || !busIf.bvalid || busIf.bresp != 2'b00) stallBad++;
        end
      end
      begin
        logic [31:0]      d;
        logic [1:0]       r;
        logic [NSTAT-1:0] p;
        readAxil(32'h008, d, r, p);
        checkOutput("t5_rd_during_stall", d, 32'hA5A5_5A5A);
        readAxil(32'h024, d, r, p);
        checkOutput("t5_stat1_during_stall", d, 32'h1111_0001);
      end
    join
    checkOutput("t5_b_stall_stable", 32'(stallBad), 32'd0);
    writeFinish();

    // Read to the same register in the commit cycle returns the old value.
    applyStimulus(32'h00C, 32'h0000_0009, 4'hF, resp, wp);
    @(negedge aclk);
    busIf.awaddr  = 32'h00C;
    busIf.wdata   = 32'h0000_0005;
    busIf.wstrb   = 4'hF;
    busIf.awvalid = 1'b1;
    busIf.wvalid  = 1'b1;
    @(negedge aclk);
    busIf.awvalid = 1'b0;
    busIf.wvalid  = 1'b0;
    checkOutput("t6_commit_bvalid_low", 32'(busIf.bvalid), 32'd0);
    checkOutput("t6_commit_arready", 32'(busIf.arready), 32'd1);
    busIf.araddr  = 32'h00C;
    busIf.arvalid = 1'b1;
    @(negedge aclk);
    busIf.arvalid = 1'b0;
    checkOutput("t6_collide_rvalid", 32'(busIf.rvalid), 32'd1);
    checkOutput("t6_collide_rdata_old", busIf.rdata, 32'h0000_0009);
    checkOutput("t6_collide_bvalid", 32'(busIf.bvalid), 32'd1);
    checkOutput("t6_collide_pulse", 32'(ctrlWrPulse), 32'h08);
    busIf.rready = 1'b1;
    busIf.bready = 1'b1;
    @(negedge aclk);
    busIf.rready = 1'b0;
    busIf.bready = 1'b0;
    readAxil(32'h00C, rd, resp, sp);
    checkOutput("t6_rdata_new", rd, 32'h0000_0005);

    // Reset while only AW is held: the captured address must be discarded.
    @(negedge aclk);
    busIf.awaddr  = 32'h010;
    busIf.awvalid = 1'b1;
    @(negedge aclk);
    busIf.awvalid = 1'b0;
    @(negedge aclk);
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    checkOutput("t6_post_rst_awready", 32'(busIf.awready), 32'd1);
    busIf.wdata  = 32'hFFFF_FFFF;
    busIf.wstrb  = 4'hF;
    busIf.wvalid = 1'b1;
    @(negedge aclk);
    busIf.wvalid = 1'b0;
    waitBad = 0;
    repeat (3) begin
      @(negedge aclk);
      if (busIf.bvalid) waitBad++;
    end
    checkOutput("t6_no_commit_after_rst", 32'(waitBad), 32'd0);
    checkOutput("t6_reg4_untouched", ctrlWord(4), 32'h0);
    busIf.awaddr  = 32'h014;
    busIf.awvalid = 1'b1;
    @(negedge aclk);
    busIf.awvalid = 1'b0;
    @(negedge aclk);
    checkOutput("t6_new_aw_bvalid", 32'(busIf.bvalid), 32'd1);
    checkOutput("t6_new_aw_pulse", 32'(ctrlWrPulse), 32'h20);
    writeFinish();
    checkOutput("t6_reg5", ctrlWord(5), 32'hFFFF_FFFF);
    checkOutput("t6_reg4_final", ctrlWord(4), 32'h0);
    checkOutput("t6_reg3_reset", ctrlWord(3), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule
